micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Next-address controller for the micro-programmed control unit. Each cycle it selects the
//  next micro-program address from: increment, absolute jump, flag-conditional branch,
//  opcode dispatch, return-to-fetch, or micro-subroutine call/return.
//  It owns the micro-PC register and a small return-address stack.
//  It sits between the control-store output fields (seq_op, branch_addr, cond_sel) and the
//  control-store address input.
// PARAMETERS
//  MPC_W       4  micro-PC width; addresses wrap modulo 2**MPC_W
//  RESET_MPC   4  fetch entry address; loaded on reset, FETCH, illegal dispatch and bad RET
//  OP_W        6  instruction opcode width
//  STACK_DEPTH 2  return-address stack entries (1..4)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-low reset (0 = reset)
//  seq_op       in   3      sequencing operation from the current microword (codes below)
//  branch_addr  in   MPC_W  target for JUMP/COND/CALL
//  cond_sel     in   2      flag select for COND: 0=zero 1=neg 2=carry 3=ovf
//  flags        in   4      ALU flags {ovf,carry,neg,zero}, sampled in the cycle of use
//  opcode       in   OP_W   instruction opcode, sampled on DISPATCH
//  stall        in   1      1 = hold micro-PC and stack; overrides seq_op
//  current_mpc  out  MPC_W  registered micro-PC, drives the control-store address
//  next_mpc     out  MPC_W  combinational next address (value loaded at next edge)
//  illegal_op   out  1      registered 1-cycle pulse: DISPATCH saw an unmapped opcode
//  stack_err    out  1      sticky: CALL while full or RET while empty; cleared only by rst
// BEHAVIOUR
//  Reset (rst=0, async): current_mpc=RESET_MPC, stack empty (count 0), illegal_op=0, stack_err=0.
//  current_mpc<=next_mpc on every rising edge with rst=1; 1-cycle latency op -> address.
//  seq_op codes (inc = current_mpc+1, wraps at 2**MPC_W-1 -> 0):
//   0 NEXT     next=inc
//   1 JUMP     next=branch_addr
//   2 COND     next= flags[cond_sel] ? branch_addr : inc
//   3 DISPATCH next=dispatch(opcode); unmapped -> RESET_MPC and illegal_op=1 next cycle
//   4 FETCH    next=RESET_MPC
//   5 CALL     push inc, next=branch_addr; if full: no push, next=branch_addr, stack_err<=1
//   6 RET      pop, next=top; if empty: next=RESET_MPC, stack_err<=1
//   7 HOLD     next=current_mpc
//  Dispatch table: 6'h00 R-type->6, 6'h23 lw->8, 6'h2B sw->10, 6'h04 beq->12,
//   6'h02 j->13, 6'h08 addi->14.
//  stall=1: next_mpc=current_mpc; no push/pop; no illegal_op; stack_err unchanged.
//   Inputs are ignored that cycle.
//  Stack is LIFO; push+pop never coincide (one op per cycle); pointer saturates, never wraps.
//  illegal_op is high for exactly the cycle after the offending DISPATCH edge.
//   Back-to-back illegal DISPATCH keeps it high.
//  Reset asserted mid-call sequence discards all stack contents; the first op after
//   deassertion executes from RESET_MPC.
//  next_mpc is purely combinational from current_mpc, stack top and inputs;
//   there are no combinational paths between outputs.
// STRUCTURE
//  Header micro_seq_defs.vh holds: SEQ_* op codes, COND_* selects, opcode constants,
//   dispatch target addresses, RESET_MPC default.
//  Sub-module micro_stack: STACK_DEPTH x MPC_W LIFO with push/pop/full/empty and the
//   same clk/rst.
//  Top holds the next-address mux, dispatch decode, micro-PC register and flag registers.
// TESTING
//  1 reset then NEXT x13 -> current_mpc 4,5,..,15,0,1 (wrap checked)
//  2 COND sel=0: zero=1, branch_addr=9 -> 9; zero=0 -> inc
//  3 DISPATCH opcode 6'h23 -> 8; opcode 6'h3F -> mpc=4 and illegal_op=1 for exactly 1 cycle
//  4 CALL 10 from 5, CALL 12 from 10, RET, RET -> 10,12,11,6
//     Third nested CALL -> stack_err=1 and jump still taken
//  5 RET on empty stack -> mpc=4, stack_err=1 sticky through 20 cycles of NEXT
//  6 stall=1 during CALL -> mpc and stack unchanged; async rst=0 mid-cycle ->
//     mpc=4 immediately, stack_err=0

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer: sequencing op codes, condition
// selects, dispatch opcodes/targets and default parameter values.
package micro_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_COND     = 3'd2,
    SEQ_DISPATCH = 3'd3,
    SEQ_FETCH    = 3'd4,
    SEQ_CALL     = 3'd5,
    SEQ_RET      = 3'd6,
    SEQ_HOLD     = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    COND_ZERO  = 2'd0,
    COND_NEG   = 2'd1,
    COND_CARRY = 2'd2,
    COND_OVF   = 2'd3
  } cond_sel_e;

  localparam int unsigned MPC_W_DEF       = 4;
  localparam int unsigned RESET_MPC_DEF   = 4;
  localparam int unsigned OP_W_DEF        = 6;
  localparam int unsigned STACK_DEPTH_DEF = 2;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  localparam int unsigned TGT_RTYPE = 6;
  localparam int unsigned TGT_LW    = 8;
  localparam int unsigned TGT_SW    = 10;
  localparam int unsigned TGT_BEQ   = 12;
  localparam int unsigned TGT_J     = 13;
  localparam int unsigned TGT_ADDI  = 14;

  // flags are packed {ovf,carry,neg,zero}
  function automatic logic flag_sel(input logic [3:0] flags, input logic [1:0] sel);
    logic result;
    case (cond_sel_e'(sel))
      COND_ZERO:  result = flags[0];
      COND_NEG:   result = flags[1];
      COND_CARRY: result = flags[2];
      COND_OVF:   result = flags[3];
      default:    result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/micro_sequencer_stack.sv
// Return-address LIFO for micro-subroutine calls. The fill count saturates at
// both ends; the caller never pushes when full nor pops when empty.
module micro_sequencer_stack
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = MPC_W_DEF,
  parameter int unsigned DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] cnt_m1_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;

  assign cnt_m1_s = count_q - CNT_W'(1);
  assign wr_idx_s = count_q[IDX_W-1:0];
  assign rd_idx_s = cnt_m1_s[IDX_W-1:0];

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));
  assign top_o   = mem_q[rd_idx_s];

  always_comb begin
    count_d = count_q;
    if (push_i && !full_o) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      count_d = cnt_m1_s;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= CNT_W'(0);
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= WIDTH'(0);
      end
    end else begin
      count_q <= count_d;
      if (push_i && !full_o) begin
        mem_q[wr_idx_s] <= data_i;
      end
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address controller for the micro-programmed control unit: owns the
// micro-PC, the return-address stack and the illegal/stack error flags.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned MPC_W       = MPC_W_DEF,
  parameter int unsigned RESET_MPC   = RESET_MPC_DEF,
  parameter int unsigned OP_W        = OP_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       seq_op_i,
  input  logic [MPC_W-1:0] branch_addr_i,
  input  logic [1:0]       cond_sel_i,
  input  logic [3:0]       flags_i,
  input  logic [OP_W-1:0]  opcode_i,
  input  logic             stall_i,
  output logic [MPC_W-1:0] current_mpc_o,
  output logic [MPC_W-1:0] next_mpc_o,
  output logic             illegal_op_o,
  output logic             stack_err_o
);

  localparam logic [MPC_W-1:0] RESET_MPC_C = MPC_W'(RESET_MPC);
  localparam logic [OP_W-1:0]  OPC_RTYPE_C = OP_W'(OPC_RTYPE);
  localparam logic [OP_W-1:0]  OPC_LW_C    = OP_W'(OPC_LW);
  localparam logic [OP_W-1:0]  OPC_SW_C    = OP_W'(OPC_SW);
  localparam logic [OP_W-1:0]  OPC_BEQ_C   = OP_W'(OPC_BEQ);
  localparam logic [OP_W-1:0]  OPC_J_C     = OP_W'(OPC_J);
  localparam logic [OP_W-1:0]  OPC_ADDI_C  = OP_W'(OPC_ADDI);

  logic [MPC_W-1:0] mpc_q;
  logic [MPC_W-1:0] mpc_d;
  logic             illegal_q;
  logic             illegal_d;
  logic             stack_err_q;
  logic             stack_err_d;
  logic [MPC_W-1:0] inc_s;
  logic [MPC_W-1:0] disp_tgt_s;
  logic             disp_valid_s;
  logic             push_s;
  logic             pop_s;
  logic [MPC_W-1:0] stk_top_s;
  logic             stk_full_s;
  logic             stk_empty_s;

  assign inc_s = mpc_q + MPC_W'(1);

  always_comb begin
    disp_valid_s = 1'b1;
    disp_tgt_s   = RESET_MPC_C;
    case (opcode_i)
      OPC_RTYPE_C: disp_tgt_s = MPC_W'(TGT_RTYPE);
      OPC_LW_C:    disp_tgt_s = MPC_W'(TGT_LW);
      OPC_SW_C:    disp_tgt_s = MPC_W'(TGT_SW);
      OPC_BEQ_C:   disp_tgt_s = MPC_W'(TGT_BEQ);
      OPC_J_C:     disp_tgt_s = MPC_W'(TGT_J);
      OPC_ADDI_C:  disp_tgt_s = MPC_W'(TGT_ADDI);
      default: begin
        disp_valid_s = 1'b0;
        disp_tgt_s   = RESET_MPC_C;
      end
    endcase
  end

  // Overflowing CALL still jumps; underflowing RET falls back to fetch.
  always_comb begin
    mpc_d       = mpc_q;
    illegal_d   = 1'b0;
    stack_err_d = stack_err_q;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (stall_i) begin
      mpc_d = mpc_q;
    end else begin
      case (seq_op_e'(seq_op_i))
        SEQ_NEXT: mpc_d = inc_s;
        SEQ_JUMP: mpc_d = branch_addr_i;
        SEQ_COND: mpc_d = flag_sel(flags_i, cond_sel_i) ? branch_addr_i : inc_s;
        SEQ_DISPATCH: begin
          mpc_d     = disp_tgt_s;
          illegal_d = !disp_valid_s;
        end
        SEQ_FETCH: mpc_d = RESET_MPC_C;
        SEQ_CALL: begin
          mpc_d = branch_addr_i;
          if (stk_full_s) begin
            stack_err_d = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end
        SEQ_RET: begin
          if (stk_empty_s) begin
            mpc_d       = RESET_MPC_C;
            stack_err_d = 1'b1;
          end else begin
            mpc_d = stk_top_s;
            pop_s = 1'b1;
          end
        end
        SEQ_HOLD: mpc_d = mpc_q;
        default:  mpc_d = mpc_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mpc_q       <= RESET_MPC_C;
      illegal_q   <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      mpc_q       <= mpc_d;
      illegal_q   <= illegal_d;
      stack_err_q <= stack_err_d;
    end
  end

  micro_sequencer_stack #(
    .WIDTH (MPC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (inc_s),
    .top_o   (stk_top_s),
    .full_o  (stk_full_s),
    .empty_o (stk_empty_s)
  );

  assign current_mpc_o = mpc_q;
  assign next_mpc_o    = mpc_d;
  assign illegal_op_o  = illegal_q;
  assign stack_err_o   = stack_err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed and randomized checks of micro_sequencer against a queue-based
// reference model of the sequencing rules.
module tb_micro_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] seq_op;
  logic [3:0] branch_addr;
  logic [1:0] cond_sel;
  logic [3:0] flags;
  logic [5:0] opcode;
  logic       stall;
  logic [3:0] current_mpc;
  logic [3:0] next_mpc;
  logic       illegal_op;
  logic       stack_err;

  int checks = 0;
  int errors = 0;

  int m_mpc;
  int m_stk[$];
  bit m_err;
  bit m_ill;
  int disp_tab[int];

  micro_sequencer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .seq_op_i      (seq_op),
    .branch_addr_i (branch_addr),
    .cond_sel_i    (cond_sel),
    .flags_i       (flags),
    .opcode_i      (opcode),
    .stall_i       (stall),
    .current_mpc_o (current_mpc),
    .next_mpc_o    (next_mpc),
    .illegal_op_o  (illegal_op),
    .stack_err_o   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int op, input int ba, input int cs,
                                    input int fl, input int opc, input bit st);
    int inc;
    inc = (m_mpc + 1) % 16;
    if (st) return m_mpc;
    case (op)
      0: return inc;
      1: return ba;
      2: return ((fl >> cs) & 1) ? ba : inc;
      3: return disp_tab.exists(opc) ? disp_tab[opc] : 4;
      4: return 4;
      5: return ba;
      6: return (m_stk.size() == 0) ? 4 : m_stk[$];
      default: return m_mpc;
    endcase
  endfunction

  task automatic step(input string tag, input int op, input int ba, input int cs,
                      input int fl, input int opc, input bit st);
    int nxt;
    @(negedge clk);
    seq_op = 3'(op); branch_addr = 4'(ba); cond_sel = 2'(cs);
    flags = 4'(fl); opcode = 6'(opc); stall = st;
    #1;
    nxt = model_next(op, ba, cs, fl, opc, st);
    check({tag, ".next"}, 32'(next_mpc), 32'(nxt));
    m_ill = 1'b0;
    if (!st) begin
      if (op == 3 && !disp_tab.exists(opc)) m_ill = 1'b1;
      if (op == 5) begin
        if (m_stk.size() == 2) m_err = 1'b1;
        else m_stk.push_back((m_mpc + 1) % 16);
      end
      if (op == 6) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else void'(m_stk.pop_back());
      end
    end
    m_mpc = nxt;
    @(posedge clk);
    #1;
    check({tag, ".mpc"}, 32'(current_mpc), 32'(m_mpc));
    check({tag, ".ill"}, 32'(illegal_op), 32'(m_ill));
    check({tag, ".serr"}, 32'(stack_err), 32'(m_err));
  endtask

  // Reset lands mid-cycle; stall keeps the following idle edge harmless.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    stall = 1'b1;
    seq_op = 3'd7;
    rst_n = 1'b0;
    #1;
    m_mpc = 4; m_stk.delete(); m_err = 1'b0; m_ill = 1'b0;
    check({tag, ".rst_mpc"}, 32'(current_mpc), 32'd4);
    check({tag, ".rst_serr"}, 32'(stack_err), 32'd0);
    check({tag, ".rst_ill"}, 32'(illegal_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int op, ba, cs, fl, opc;
    int valid_ops[6];
    bit st;
    disp_tab[6'h00] = 6; disp_tab[6'h23] = 8; disp_tab[6'h2B] = 10;
    disp_tab[6'h04] = 12; disp_tab[6'h02] = 13; disp_tab[6'h08] = 14;
    valid_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    rst_n = 1'b0; seq_op = 3'd7; branch_addr = 4'd0; cond_sel = 2'd0;
    flags = 4'd0; opcode = 6'd0; stall = 1'b1;
    m_mpc = 4; m_err = 1'b0; m_ill = 1'b0;

    // 1: reset then increments across the wrap
    do_reset("t1");
    for (int i = 0; i < 13; i++) step("t1_next", 0, 0, 0, 0, 0, 1'b0);
    check("t1_wrap", 32'(current_mpc), 32'd1);

    // 2: conditional branch on zero flag
    step("t2_taken", 2, 9, 0, 4'b0001, 0, 1'b0);
    check("t2_at9", 32'(current_mpc), 32'd9);
    step("t2_nottaken", 2, 3, 0, 4'b1110, 0, 1'b0);
    check("t2_inc", 32'(current_mpc), 32'd10);

    // 3: dispatch, illegal pulse width and back-to-back illegal
    step("t3_lw", 3, 0, 0, 0, 6'h23, 1'b0);
    check("t3_at8", 32'(current_mpc), 32'd8);
    step("t3_bad", 3, 0, 0, 0, 6'h3F, 1'b0);
    check("t3_ill_hi", 32'(illegal_op), 32'd1);
    step("t3_after", 0, 0, 0, 0, 0, 1'b0);
    check("t3_ill_lo", 32'(illegal_op), 32'd0);
    step("t3_bad2a", 3, 0, 0, 0, 6'h11, 1'b0);
    step("t3_bad2b", 3, 0, 0, 0, 6'h3E, 1'b0);
    check("t3_b2b", 32'(illegal_op), 32'd1);

    // 4: nested calls and returns, then overflow
    do_reset("t4");
    step("t4_to5", 0, 0, 0, 0, 0, 1'b0);
    step("t4_call10", 5, 10, 0, 0, 0, 1'b0);
    check("t4_at10", 32'(current_mpc), 32'd10);
    step("t4_call12", 5, 12, 0, 0, 0, 1'b0);
    step("t4_ret1", 6, 0, 0, 0, 0, 1'b0);
    check("t4_at11", 32'(current_mpc), 32'd11);
    step("t4_ret2", 6, 0, 0, 0, 0, 1'b0);
    check("t4_at6", 32'(current_mpc), 32'd6);
    step("t4_c1", 5, 1, 0, 0, 0, 1'b0);
    step("t4_c2", 5, 2, 0, 0, 0, 1'b0);
    step("t4_c3", 5, 3, 0, 0, 0, 1'b0);
    check("t4_ovf_err", 32'(stack_err), 32'd1);
    check("t4_ovf_jump", 32'(current_mpc), 32'd3);

    // 5: return on empty stack, sticky error
    do_reset("t5");
    step("t5_ret", 6, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) step("t5_sticky", 0, 0, 0, 0, 0, 1'b0);
    check("t5_serr", 32'(stack_err), 32'd1);

    // 6: stalled call is ignored; async reset clears everything
    do_reset("t6");
    step("t6_to5", 0, 0, 0, 0, 0, 1'b0);
    step("t6_call10", 5, 10, 0, 0, 0, 1'b0);
    step("t6_stall", 5, 12, 0, 0, 6'h3F, 1'b1);
    check("t6_hold", 32'(current_mpc), 32'd10);
    step("t6_ret", 6, 0, 0, 0, 0, 1'b0);
    check("t6_ret6", 32'(current_mpc), 32'd6);
    step("t6_ret_empty", 6, 0, 0, 0, 0, 1'b0);
    step("t6_call", 5, 9, 0, 0, 0, 1'b0);
    do_reset("t6_mid");
    step("t6_ret_after", 6, 0, 0, 0, 0, 1'b0);

    // random phase against the reference model
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      op  = int'($urandom_range(0, 7));
      ba  = int'($urandom_range(0, 15));
      cs  = int'($urandom_range(0, 3));
      fl  = int'($urandom_range(0, 15));
      opc = ($urandom_range(0, 1) == 0) ? valid_ops[$urandom_range(0, 5)]
                                        : int'($urandom_range(0, 63));
      st  = ($urandom_range(0, 7) == 0);
      step("rnd", op, ba, cs, fl, opc, st);
      if (i % 97 == 96) do_reset("rnd_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
